// File: rtl/div_issue_queue.sv
// In-order issue queue feeding a single non-pipelined divider, with branch-flush pruning.
// Optional DIV_ISSUE_BYPASS_EN lets a uop skip storage when the queue is empty and the divider is free.
package div_issue_pkg;
  parameter int unsigned SqnWidth = 7;

  typedef struct packed {
    logic                taken;
    logic [SqnWidth-1:0] sqN;
  } BranchProv;

  typedef struct packed {
    logic                valid;
    logic [SqnWidth-1:0] sqN;
    logic [5:0]          tag_dst;
    logic [1:0]          opcode;
    logic [31:0]         src_a;
    logic [31:0]         src_b;
  } EX_UOp;

  // Younger-than-branch test on wrapping sequence numbers.
  function automatic logic is_flushed(input logic [SqnWidth-1:0] sqn, input BranchProv br);
    logic [SqnWidth-1:0] diff;
    diff = sqn - br.sqN;
    return br.taken && !diff[SqnWidth-1] && (diff != '0);
  endfunction
endpackage

module div_issue_queue
  import div_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  BranchProv IN_branch,
  input  EX_UOp     IN_uop,
  output logic      OUT_stall,
  output logic      OUT_en,
  output EX_UOp     OUT_uop,
  input  logic      IN_divBusy,
  input  logic      IN_divResValid
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  EX_UOp               mem_q [DEPTH];
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d, wr_idx;
  logic [CntW-1:0]     count_q, count_d, survivors;
  logic                in_flight_q, in_flight_d;
  logic [SqnWidth-1:0] in_flight_sqn_q, in_flight_sqn_d;
  logic                out_en_q, out_en_d;
  EX_UOp               out_uop_q, out_uop_d;
  EX_UOp               issue_uop;
  logic                div_ready, in_ok, push, pop, bypass, keep;

  // Entries are sqN-ordered, so survivors of a flush form a prefix starting at head.
  always_comb begin
    survivors = '0;
    keep      = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CntW'(i) >= count_q || is_flushed(mem_q[head_q + PtrW'(i)].sqN, IN_branch)) begin
        keep = 1'b0;
      end
      if (keep) survivors = survivors + CntW'(1);
    end
  end

  assign OUT_stall = (count_q == CntW'(DEPTH));
  assign div_ready = !IN_divBusy && (!in_flight_q || IN_divResValid);
  assign in_ok     = IN_uop.valid && !is_flushed(IN_uop.sqN, IN_branch);
  assign pop       = div_ready && (survivors != '0);

`ifdef DIV_ISSUE_BYPASS_EN
  assign bypass = in_ok && div_ready && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push   = in_ok && !OUT_stall && !bypass;
  assign wr_idx = IN_branch.taken ? head_q + survivors[PtrW-1:0] : tail_q;

  always_comb begin
    head_d          = pop ? head_q + PtrW'(1) : head_q;
    tail_d          = push ? wr_idx + PtrW'(1) : wr_idx;
    count_d         = survivors + CntW'(push) - CntW'(pop);
    in_flight_d     = in_flight_q;
    in_flight_sqn_d = in_flight_sqn_q;
    out_en_d        = 1'b0;
    out_uop_d       = out_uop_q;
    out_uop_d.valid = 1'b0;
    issue_uop       = bypass ? IN_uop : mem_q[head_q];

    if (IN_divResValid || (in_flight_q && is_flushed(in_flight_sqn_q, IN_branch))) begin
      in_flight_d = 1'b0;
    end
    if (pop || bypass) begin
      in_flight_d     = 1'b1;
      in_flight_sqn_d = issue_uop.sqN;
      out_en_d        = 1'b1;
      out_uop_d       = issue_uop;
      out_uop_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      in_flight_q     <= 1'b0;
      in_flight_sqn_q <= '0;
      out_en_q        <= 1'b0;
      out_uop_q       <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      in_flight_q     <= in_flight_d;
      in_flight_sqn_q <= in_flight_sqn_d;
      out_en_q        <= out_en_d;
      out_uop_q       <= out_uop_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= IN_uop;
  end

  assign OUT_en  = out_en_q;
  assign OUT_uop = out_uop_q;

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue (default build, bypass disabled).
module tb_div_issue_queue;
  import div_issue_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  BranchProv IN_branch;
  EX_UOp     IN_uop;
  logic      OUT_stall;
  logic      OUT_en;
  EX_UOp     OUT_uop;
  logic      IN_divBusy;
  logic      IN_divResValid;

  int checks   = 0;
  int failures = 0;

  div_issue_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_branch      (IN_branch),
    .IN_uop         (IN_uop),
    .OUT_stall      (OUT_stall),
    .OUT_en         (OUT_en),
    .OUT_uop        (OUT_uop),
    .IN_divBusy     (IN_divBusy),
    .IN_divResValid (IN_divResValid)
  );

  always #5 clk = ~clk;

  function automatic EX_UOp mk(input int s);
    EX_UOp u;
    u         = '0;
    u.valid   = 1'b1;
    u.sqN     = SqnWidth'(s);
    u.tag_dst = 6'(s);
    u.opcode  = 2'd1;
    u.src_a   = 32'hA000 + 32'(s);
    u.src_b   = 32'h10 + 32'(s);
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int s);
    chk({tag, "_en"}, 32'(OUT_en), 32'd1);
    chk({tag, "_sqn"}, 32'(OUT_uop.sqN), 32'(s));
  endtask

  initial begin
    rst            = 1'b1;
    IN_branch      = '0;
    IN_uop         = '0;
    IN_divBusy     = 1'b0;
    IN_divResValid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_en", 32'(OUT_en), 32'd0);
    chk("rst_valid", 32'(OUT_uop.valid), 32'd0);
    chk("rst_stall", 32'(OUT_stall), 32'd0);
    chk("rst_count", 32'(dut.count_q), 32'd0);

    // Single uop, idle divider: two-edge latency.
    IN_uop = mk(5);
    tick();
    IN_uop = '0;
    chk("lat_en_early", 32'(OUT_en), 32'd0);
    chk("lat_count", 32'(dut.count_q), 32'd1);
    tick();
    chk_out("lat", 5);
    chk("lat_src_a", OUT_uop.src_a, 32'hA005);
    chk("lat_inflight", 32'(dut.in_flight_q), 32'd1);
    tick();
    chk("lat_en_once", 32'(OUT_en), 32'd0);
    chk("lat_valid_once", 32'(OUT_uop.valid), 32'd0);
    IN_divResValid = 1'b1;
    tick();
    IN_divResValid = 1'b0;
    chk("res_clears_inflight", 32'(dut.in_flight_q), 32'd0);

    // Fill while busy; overflow push discarded.
    IN_divBusy = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      IN_uop = mk(s);
      tick();
    end
    chk("full_stall", 32'(OUT_stall), 32'd1);
    chk("full_count", 32'(dut.count_q), 32'd4);
    IN_uop = mk(20);
    tick();
    IN_uop = '0;
    chk("ovf_count", 32'(dut.count_q), 32'd4);
    chk("ovf_stall", 32'(OUT_stall), 32'd1);
    IN_divBusy     = 1'b0;
    IN_divResValid = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      tick();
      chk_out("drain", s);
    end
    chk("drain_stall", 32'(OUT_stall), 32'd0);
    tick();
    chk("drain_empty_en", 32'(OUT_en), 32'd0);
    IN_divResValid = 1'b0;

    // Branch at sqN 11 prunes 12 and 13.
    IN_divBusy = 1'b1;
    for (int s = 10; s <= 13; s++) begin
      IN_uop = mk(s);
      tick();
    end
    IN_uop          = '0;
    IN_branch.taken = 1'b1;
    IN_branch.sqN   = 7'd11;
    tick();
    IN_branch = '0;
    chk("flush_count", 32'(dut.count_q), 32'd2);
    IN_divBusy     = 1'b0;
    IN_divResValid = 1'b1;
    tick();
    chk_out("flush_iss0", 10);
    tick();
    chk_out("flush_iss1", 11);
    tick();
    chk("flush_iss_end", 32'(OUT_en), 32'd0);
    chk("flush_empty", 32'(dut.count_q), 32'd0);
    IN_divResValid = 1'b0;

    // Result-valid frees the divider for the next head in the same cycle.
    IN_uop = mk(7);
    tick();
    IN_uop = mk(8);
    tick();
    IN_uop = '0;
    chk_out("inf_first", 7);
    chk("pushpop_count", 32'(dut.count_q), 32'd1);
    tick();
    chk("inf_block_en", 32'(OUT_en), 32'd0);
    chk("inf_block_count", 32'(dut.count_q), 32'd1);
    IN_divResValid = 1'b1;
    tick();
    chk_out("inf_next", 8);
    tick();
    chk("inf_idle_en", 32'(OUT_en), 32'd0);
    IN_divResValid = 1'b0;

    // Incoming uop younger than a same-cycle branch is rejected.
    IN_divBusy = 1'b1;
    IN_uop     = mk(6);
    tick();
    IN_uop = mk(7);
    tick();
    IN_uop          = mk(9);
    IN_branch.taken = 1'b1;
    IN_branch.sqN   = 7'd8;
    tick();
    IN_uop    = '0;
    IN_branch = '0;
    chk("pushflush_count", 32'(dut.count_q), 32'd2);

    // Reset mid-queue, with an issue otherwise due.
    rst        = 1'b1;
    IN_divBusy = 1'b0;
    tick();
    rst = 1'b0;
    chk("mrst_count", 32'(dut.count_q), 32'd0);
    chk("mrst_en", 32'(OUT_en), 32'd0);
    chk("mrst_inflight", 32'(dut.in_flight_q), 32'd0);
    IN_uop = mk(30);
    tick();
    IN_uop = '0;
    chk("mrst_push_count", 32'(dut.count_q), 32'd1);
    tick();
    chk_out("mrst_iss", 30);

    // Flushing the in-flight uop frees the divider.
    IN_branch.taken = 1'b1;
    IN_branch.sqN   = 7'd25;
    tick();
    IN_branch = '0;
    chk("iflush_inflight", 32'(dut.in_flight_q), 32'd0);
    IN_uop = mk(26);
    tick();
    IN_uop = '0;
    tick();
    chk_out("iflush_iss", 26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
